// File: rtl/mlp_pkg.sv
// Shared constants, state encoding and saturation helper for the SDRAM-resident MNIST MLP.
package mlp_pkg;

  localparam int unsigned N_IN       = 784;
  localparam int unsigned N_HID      = 200;
  localparam int unsigned N_OUT      = 10;
  localparam int unsigned ACC_W      = 40;
  localparam int unsigned FRAC_SHIFT = 8;

  localparam logic [31:0] BASE_IMG = 32'd0;
  localparam logic [31:0] BASE_W1  = 32'd2_000;
  localparam logic [31:0] BASE_W2  = 32'd320_000;
  localparam logic [31:0] BASE_L1  = 32'd400_000;
  localparam logic [31:0] BASE_L2  = 32'd450_000;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

  typedef enum logic [7:0] {
    IDLE   = 8'd0,
    RD_L1  = 8'd1,
    WT_L1  = 8'd2,
    RD_W2  = 8'd3,
    WT_W2  = 8'd4,
    MAC    = 8'd5,
    WR_L2  = 8'd6,
    NEXT   = 8'd7,
    WR_RES = 8'd8,
    DONE   = 8'd9
  } state_t;

  function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > SAT_HI) return 16'sh7FFF;
    if (v < SAT_LO) return 16'sh8000;
    return v[15:0];
  endfunction

endpackage

// File: rtl/mac_sat.sv
// Registered signed 16x16 multiply-accumulate; score is the shifted, saturated accumulator.
module mac_sat
  import mlp_pkg::*;
#(
  parameter int unsigned SHIFT = FRAC_SHIFT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               en,
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic signed [15:0] score
);

  logic signed [ACC_W-1:0] acc;
  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    prod    = a * b;
    shifted = acc >>> SHIFT;
    score   = sat16(shifted);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/layer2_classifier.sv
// MLP output layer: ReLU-buffers the layer-1 sums, scores 10 nodes against W2 and
// writes the scores plus the argmax digit back to SDRAM over an Avalon master.
module layer2_classifier
  import mlp_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        waitrequest,
  input  logic        readdatavalid,
  input  logic [15:0] readdata,
  output logic        chipselect,
  output logic [1:0]  byteenable,
  output logic        read_n,
  output logic        write_n,
  output logic [31:0] address,
  output logic [15:0] writedata,
  input  logic        ready,
  output logic        done,
  output logic [3:0]  result,
  output logic [31:0] toHexLed
);

  localparam logic [7:0] LAST_HID = 8'(N_HID - 1);
  localparam logic [7:0] LAST_OUT = 8'(N_OUT - 1);

  state_t             state;
  logic [7:0]         idx;
  logic [7:0]         node;
  logic signed [15:0] weight;
  logic signed [15:0] best_val;
  logic [3:0]         best_idx;
  logic [15:0]        hid_buf [N_HID];
  logic signed [15:0] score;
  logic               mac_clear;
  logic               mac_en;
  logic [31:0]        l1_addr;
  logic [31:0]        w2_addr;
  logic [31:0]        l2_addr;

  assign chipselect = 1'b1;
  assign byteenable = 2'b11;
  assign toHexLed   = {node, idx, 8'h00, state};

  always_comb begin
    l1_addr   = BASE_L1 + {23'h0, idx, 1'b0};
    w2_addr   = BASE_W2 + ((32'(node) * 32'(N_HID) + 32'(idx)) << 1);
    l2_addr   = BASE_L2 + {23'h0, node, 1'b0};
    mac_clear = (state == IDLE) || (state == NEXT);
    mac_en    = (state == MAC);
  end

  mac_sat #(
    .SHIFT(FRAC_SHIFT)
  ) u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (mac_clear),
    .en      (mac_en),
    .a       (hid_buf[idx]),
    .b       (weight),
    .score   (score)
  );

  always_ff @(posedge clk) begin
    if (state == WT_L1 && readdatavalid) begin
      hid_buf[idx] <= readdata[15] ? '0 : readdata;
    end
  end

  // Each bus state issues its request on entry, then holds it until waitrequest drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      read_n    <= 1'b1;
      write_n   <= 1'b1;
      address   <= '0;
      writedata <= '0;
      done      <= 1'b0;
      result    <= '0;
      idx       <= '0;
      node      <= '0;
      weight    <= '0;
      best_val  <= '0;
      best_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (ready) begin
            idx   <= '0;
            node  <= '0;
            state <= RD_L1;
          end
        end
        RD_L1: begin
          if (read_n) begin
            read_n  <= 1'b0;
            address <= l1_addr;
          end else if (!waitrequest) begin
            read_n <= 1'b1;
            state  <= WT_L1;
          end
        end
        WT_L1: begin
          if (readdatavalid) begin
            if (idx < LAST_HID) begin
              idx   <= idx + 8'd1;
              state <= RD_L1;
            end else begin
              idx   <= '0;
              node  <= '0;
              state <= RD_W2;
            end
          end
        end
        RD_W2: begin
          if (read_n) begin
            read_n  <= 1'b0;
            address <= w2_addr;
          end else if (!waitrequest) begin
            read_n <= 1'b1;
            state  <= WT_W2;
          end
        end
        WT_W2: begin
          if (readdatavalid) begin
            weight <= readdata;
            state  <= MAC;
          end
        end
        MAC: begin
          if (idx < LAST_HID) begin
            idx   <= idx + 8'd1;
            state <= RD_W2;
          end else begin
            state <= WR_L2;
          end
        end
        WR_L2: begin
          if (write_n) begin
            write_n   <= 1'b0;
            address   <= l2_addr;
            writedata <= score;
          end else if (!waitrequest) begin
            write_n <= 1'b1;
            if (node == '0 || $signed(writedata) > best_val) begin
              best_val <= writedata;
              best_idx <= node[3:0];
            end
            state <= NEXT;
          end
        end
        NEXT: begin
          idx <= '0;
          if (node < LAST_OUT) begin
            node  <= node + 8'd1;
            state <= RD_W2;
          end else begin
            state <= WR_RES;
          end
        end
        WR_RES: begin
          if (write_n) begin
            write_n   <= 1'b0;
            address   <= BASE_L2 + 32'(2 * N_OUT);
            writedata <= {12'h000, best_idx};
          end else if (!waitrequest) begin
            write_n <= 1'b1;
            result  <= best_idx;
            state   <= DONE;
          end
        end
        DONE: begin
          if (ready) begin
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
